muldiv_result_disp: RTL



---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/bin2bcd_lane.sv | 40 ++++
 rtl/muldiv_result_disp.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide result display path.
package muldiv_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, CONV, SHOW} state_t;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam int         SEG_DP_BIT = 7;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    // Active-low segment patterns, bit order g..a
    localparam logic [6:0] SEG_TABLE [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    function automatic logic [6:0] seg_of(input logic [3:0] digit);
        if (digit > 4'd9) begin
            return SEG_BLANK;
        end
        return SEG_TABLE[digit];
    endfunction

endpackage

// File: rtl/bin2bcd_lane.sv
// One double-dabble lane: 8-bit binary into three BCD nibbles, one shift per step.
module bin2bcd_lane
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [7:0]  bin,
    output logic [11:0] bcd_step
);

    logic [11:0] bcd;
    logic [11:0] adj;
    logic [7:0]  shreg;

    // bcd_step is the value this lane will hold after the current step
    always_comb begin
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        bcd_step = {adj[10:0], shreg[7]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd   <= '0;
            shreg <= '0;
        end else if (load) begin
            bcd   <= '0;
            shreg <= bin;
        end else if (step) begin
            bcd   <= bcd_step;
            shreg <= {shreg[6:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_result_disp.sv
// Captures a multiply/divide result, converts it to BCD and scans it onto a 4-digit display.
// Optional leading-zero blanking is enabled by defining MULDIV_DISP_LZB_EN.
module muldiv_result_disp
#(
    parameter int SCAN_DIV = 50000,
    parameter int N_ITER   = 8
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       mode,
    input  logic [7:0] din,
    output logic       busy,
    output logic [7:0] seg,
    output logic [3:0] an
);

    import muldiv_pkg::*;

    localparam int CNT_W  = $clog2(SCAN_DIV);
    localparam int ITER_W = $clog2(N_ITER + 1);
    localparam logic [7:0] DIGIT_BLANK = {1'b1, SEG_BLANK};

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              last_iter;
    logic              lane_load;
    logic              lane_step;
    logic [7:0]        din_q;
    logic              mode_q;
    logic [ITER_W-1:0] iter;
    logic [7:0]        bin_a;
    logic [7:0]        bin_b;
    logic [11:0]       step_a;
    logic [11:0]       step_b;
    logic [3:0]        unused_b_hund;
    logic [3:0][7:0]   disp;
    logic [3:0][7:0]   disp_nxt;
    logic [CNT_W-1:0]  scan_cnt;
    logic [1:0]        scan_idx;

    assign accept        = in_valid && in_ready;
    assign last_iter     = (state == CONV) && (iter == ITER_W'(N_ITER - 1));
    assign unused_b_hund = step_b[11:8];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)    state_nxt = LOAD;
            LOAD:                   state_nxt = CONV;
            CONV:    if (last_iter) state_nxt = SHOW;
            SHOW:    if (accept)    state_nxt = LOAD;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) || (state == SHOW);
        busy      = (state == LOAD) || (state == CONV);
        lane_load = (state == LOAD);
        lane_step = (state == CONV);
    end

    assign bin_a = (mode_q == MODE_DIV) ? {4'b0, din_q[3:0]} : din_q;
    assign bin_b = (mode_q == MODE_DIV) ? {4'b0, din_q[7:4]} : 8'h00;

    bin2bcd_lane u_lane_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lane_load),
        .step     (lane_step),
        .bin      (bin_a),
        .bcd_step (step_a)
    );

    bin2bcd_lane u_lane_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lane_load),
        .step     (lane_step),
        .bin      (bin_b),
        .bcd_step (step_b)
    );

    // Digits are built from the final step value so the display swaps in one edge
    always_comb begin
        disp_nxt = {4{DIGIT_BLANK}};
        if (mode_q == MODE_MUL) begin
            disp_nxt[2] = {1'b1, seg_of(step_a[11:8])};
            disp_nxt[1] = {1'b1, seg_of(step_a[7:4])};
            disp_nxt[0] = {1'b1, seg_of(step_a[3:0])};
`ifdef MULDIV_DISP_LZB_EN
            if (step_a[11:8] == 4'd0) disp_nxt[2] = DIGIT_BLANK;
            if (step_a[11:4] == 8'd0) disp_nxt[1] = DIGIT_BLANK;
`endif
        end else begin
            disp_nxt[3] = {1'b1, seg_of(step_b[7:4])};
            disp_nxt[2] = {1'b1, seg_of(step_b[3:0])};
            disp_nxt[2][SEG_DP_BIT] = 1'b0;
            disp_nxt[1] = {1'b1, seg_of(step_a[7:4])};
            disp_nxt[0] = {1'b1, seg_of(step_a[3:0])};
`ifdef MULDIV_DISP_LZB_EN
            if (step_b[7:4] == 4'd0) disp_nxt[3] = DIGIT_BLANK;
            if (step_a[7:4] == 4'd0) disp_nxt[1] = DIGIT_BLANK;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            din_q  <= '0;
            mode_q <= MODE_MUL;
            iter   <= '0;
            disp   <= {4{DIGIT_BLANK}};
        end else begin
            if (accept) begin
                din_q  <= din;
                mode_q <= mode;
            end
            if (lane_step) begin
                iter <= iter + ITER_W'(1);
            end else begin
                iter <= '0;
            end
            if (last_iter) begin
                disp <= disp_nxt;
            end
        end
    end

    // seg and an come from the same edge so a digit never shows under the wrong anode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            scan_idx <= '0;
            seg      <= DIGIT_BLANK;
            an       <= 4'hF;
        end else begin
            if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                scan_idx <= scan_idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + CNT_W'(1);
            end
            seg <= disp[scan_idx];
            an  <= ~(4'b0001 << scan_idx);
        end
    end

endmodule
